i2c_slave_controller: RTL and testbench

//   I2C target (slave) that responds to the team's I2C master on the same SCL/SDA bus.

---
 rtl/i2c_slave_controller.sv | 196 +++++++++++++++++++
 tb/tb_i2c_slave_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_controller.sv
// I2C target (slave) controller.
// Oversamples SCL/SDA on core_clk, detects START/STOP, matches a 7-bit address and moves
// data bytes to an external RX FIFO (write) or from an external TX FIFO (read).
// SCL is input only; the target never stretches the clock.
//
// Ports:
//   core_clk, rst_n        system clock (>=16x SCL) and async active-low reset
//   enable                 0 forces IDLE and releases SDA
//   own_address            7-bit target address
//   scl_in, sda_in         asynchronous bus pin levels
//   sda_oe                 1 pulls SDA low (open-drain)
//   rx_data/rx_valid       received byte and its one-cycle push strobe
//   rx_full/rx_overflow    RX FIFO full input; pulse when a byte is NACKed because of it
//   tx_data/tx_valid       TX FIFO head and not-empty flag
//   tx_ready               one-cycle pop strobe for the TX FIFO
//   busy, rw               addressed-transfer flag and R/W bit of the last matched address
module i2c_slave_controller #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [7:0]  IDLE_TX_BYTE = 8'hFF
) (
    input  logic       core_clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] own_address,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_full,
    output logic       rx_overflow,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       rw
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StRxData, StRxAck, StTxData, StTxAck, StWaitStop
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_q, sda_q;
    logic [3:0]             bit_cnt_q;
    logic [7:0]             shift_q;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] tx_byte;

    // Synchronizers reset to the idle bus level so reset release creates no false START.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_q      <= scl_s;
            sda_q      <= sda_s;
        end
    end

    always_comb begin
        scl_s     = scl_sync_q[SYNC_STAGES-1];
        sda_s     = sda_sync_q[SYNC_STAGES-1];
        scl_rise  = scl_s & ~scl_q;
        scl_fall  = ~scl_s & scl_q;
        start_det = scl_s & scl_q & sda_q & ~sda_s;
        stop_det  = scl_s & scl_q & ~sda_q & sda_s;
        tx_byte   = tx_valid ? tx_data : IDLE_TX_BYTE;
    end

    // bit_cnt_q counts received bits (0..8) in ADDR/RX_DATA and remaining bits in TX_DATA.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            sda_oe      <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_overflow <= 1'b0;
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
            rw          <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            rx_overflow <= 1'b0;
            tx_ready    <= 1'b0;
            if (!enable) begin
                state_q <= StIdle;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (start_det) begin
                state_q   <= StAddr;
                bit_cnt_q <= 4'd0;
                sda_oe    <= 1'b0;
            end else if (stop_det) begin
                state_q <= StIdle;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    StAddr: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                // Address is the 7 bits already shifted; sda_s is R/W.
                                if (shift_q[6:0] == own_address) begin
                                    state_q <= StAddrAck;
                                    rw      <= sda_s;
                                    busy    <= 1'b1;
                                end else begin
                                    state_q <= StWaitStop;
                                    busy    <= 1'b0;
                                end
                            end
                        end
                    end
                    StAddrAck: begin
                        // First fall drives the ACK, second fall ends the ACK slot.
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (rw) begin
                                shift_q   <= tx_byte;
                                sda_oe    <= ~tx_byte[7];
                                tx_ready  <= tx_valid;
                                bit_cnt_q <= 4'd7;
                                state_q   <= StTxData;
                            end else begin
                                sda_oe    <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                state_q   <= StRxData;
                            end
                        end
                    end
                    StRxData: begin
                        if (scl_rise && bit_cnt_q != 4'd8) begin
                            shift_q   <= {shift_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            if (!rx_full) begin
                                rx_data  <= shift_q;
                                rx_valid <= 1'b1;
                                sda_oe   <= 1'b1;
                                state_q  <= StRxAck;
                            end else begin
                                rx_overflow <= 1'b1;
                                state_q     <= StWaitStop;
                            end
                        end
                    end
                    StRxAck: begin
                        if (scl_fall) begin
                            sda_oe    <= 1'b0;
                            bit_cnt_q <= 4'd0;
                            state_q   <= StRxData;
                        end
                    end
                    StTxData: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd0) begin
                                sda_oe  <= 1'b0;
                                state_q <= StTxAck;
                            end else begin
                                sda_oe    <= ~shift_q[6];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q - 4'd1;
                            end
                        end
                    end
                    StTxAck: begin
                        if (scl_rise && sda_s) begin
                            state_q <= StWaitStop;
                        end else if (scl_fall) begin
                            shift_q   <= tx_byte;
                            sda_oe    <= ~tx_byte[7];
                            tx_ready  <= tx_valid;
                            bit_cnt_q <= 4'd7;
                            state_q   <= StTxData;
                        end
                    end
                    default: ; // StIdle, StWaitStop: only START/STOP/enable act
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Self-checking bench for i2c_slave_controller.
// A bus master drives SCL/SDA at bit level; a transaction-level model predicts the ACK/NACK
// of every byte slot, the bytes a read must return, and the rx_valid/rx_overflow/tx_ready
// pulses, which a per-cycle monitor matches against the DUT.
module tb_i2c_slave_controller;

    localparam int Q = 8; // core_clk cycles per quarter SCL period

    logic       core_clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [6:0] own_address;
    logic       m_scl, m_sda;
    logic       scl_in, sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_full, rx_overflow;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, busy, rw;

    always #5 core_clk = ~core_clk;

    // Open-drain bus: master and target can only pull low.
    assign scl_in = m_scl;
    assign sda_in = m_sda & ~sda_oe;

    i2c_slave_controller #(.SYNC_STAGES(2), .IDLE_TX_BYTE(8'hFF)) dut (
        .core_clk(core_clk), .rst_n(rst_n), .enable(enable), .own_address(own_address),
        .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_full(rx_full), .rx_overflow(rx_overflow),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .rw(rw)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_rx_q[$];
    int         exp_ovf = 0;
    int         exp_txr = 0;
    int         rx_total = 0, ovf_total = 0, txr_total = 0;
    logic       oe_seen = 1'b0;
    logic       prev_oe = 1'b0;
    int         scl_hi = 0;
    logic [7:0] rd_log[$];

    logic [7:0] pl_data[4];
    logic [3:0] pl_full;
    logic [3:0] pl_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor: every strobe must be one the model predicted.
    always @(negedge core_clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rx_total++;
                if (exp_rx_q.size() == 0) check("rx_valid_unexpected", 32'd1, 32'd0);
                else check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
            end
            if (rx_overflow) begin
                ovf_total++;
                check("rx_overflow_expected", 32'(exp_ovf > 0), 32'd1);
                if (exp_ovf > 0) exp_ovf--;
            end
            if (tx_ready) begin
                txr_total++;
                check("tx_ready_expected", 32'(exp_txr > 0), 32'd1);
                check("tx_ready_with_valid", 32'(tx_valid), 32'd1);
                if (exp_txr > 0) exp_txr--;
            end
            if (sda_oe) oe_seen = 1'b1;
            if (enable && scl_in && scl_hi > 4)
                check("oe_stable_scl_high", 32'(sda_oe), 32'(prev_oe));
        end
        scl_hi  = scl_in ? scl_hi + 1 : 0;
        prev_oe = sda_oe;
    end

    task automatic wq();
        repeat (Q) @(posedge core_clk);
        #1;
    endtask

    task automatic bit_cyc(input logic b, output logic r);
        m_sda = b;
        wq();
        m_scl = 1'b1;
        wq();
        r = sda_in;
        wq();
        m_scl = 1'b0;
        wq();
    endtask

    task automatic start_cond();
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b0; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b1; wq();
    endtask

    task automatic send_bits(input logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) bit_cyc(b[i], r);
    endtask

    task automatic read_bits(output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_cyc(1'b1, r);
            d[i] = r;
        end
    endtask

    // One addressed transfer (START or repeated START, no STOP) using pl_* as payload.
    // Write: pl_data are the bytes sent, pl_full[k] is rx_full during byte k.
    // Read: pl_data/pl_valid are the TX FIFO head presented for byte k.
    task automatic xfer(input logic [6:0] addr, input logic rd, input int n);
        logic r, matched, alive;
        logic [7:0] d, exp_b;
        matched = enable && (addr == own_address);
        exp_b   = 8'hFF;
        start_cond();
        send_bits({addr, rd});
        if (rd && matched) begin
            tx_data  = pl_data[0];
            tx_valid = pl_valid[0];
            exp_b    = pl_valid[0] ? pl_data[0] : 8'hFF;
            if (pl_valid[0]) exp_txr++;
        end
        bit_cyc(1'b1, r);
        check("addr_ack", 32'(!r), 32'(matched));
        check("busy_after_addr", 32'(busy), 32'(matched));
        if (matched) check("rw", 32'(rw), 32'(rd));
        alive = matched;
        for (int k = 0; k < n; k++) begin
            if (!rd) begin
                rx_full = pl_full[k];
                if (alive) begin
                    if (pl_full[k]) exp_ovf++;
                    else exp_rx_q.push_back(pl_data[k]);
                end
                send_bits(pl_data[k]);
                rx_full = 1'b0;
                bit_cyc(1'b1, r);
                check("data_ack", 32'(!r), 32'(alive && !pl_full[k]));
                if (pl_full[k]) alive = 1'b0;
            end else begin
                read_bits(d);
                rd_log.push_back(d);
                check("rd_byte", 32'(d), 32'(alive ? exp_b : 8'hFF));
                if (k < n - 1 && alive) begin
                    tx_data  = pl_data[k+1];
                    tx_valid = pl_valid[k+1];
                    exp_b    = pl_valid[k+1] ? pl_data[k+1] : 8'hFF;
                    if (pl_valid[k+1]) exp_txr++;
                end
                bit_cyc(k == n - 1, r); // ACK all but the last byte
            end
        end
        tx_valid = 1'b0;
    endtask

    task automatic finish_xfer();
        stop_cond();
        repeat (5) @(posedge core_clk);
        #1;
        check("busy_after_stop", 32'(busy), 32'd0);
        check("rx_pulses_drained", 32'(exp_rx_q.size()), 32'd0);
        check("ovf_pulses_drained", 32'(exp_ovf), 32'd0);
        check("txr_pulses_drained", 32'(exp_txr), 32'd0);
        exp_rx_q.delete();
        exp_ovf = 0;
        exp_txr = 0;
    endtask

    initial begin
        #990000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rx, base_ovf, base_txr;
        m_scl = 1'b1; m_sda = 1'b1; enable = 1'b1; own_address = 7'h50;
        rx_full = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        rst_n = 1'b0;
        repeat (4) @(posedge core_clk);
        #1;
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_pulses", 32'({rx_valid, rx_overflow, tx_ready}), 32'd0);
        check("rst_busy_rw", 32'({busy, rw}), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge core_clk);
        #1;

        // Write 0x3C, 0x81 to 0x50.
        base_rx = rx_total;
        pl_data = '{8'h3C, 8'h81, 8'h00, 8'h00}; pl_full = 4'b0000;
        xfer(7'h50, 1'b0, 2);
        check("lit_rw_write", 32'(rw), 32'd0);
        finish_xfer();
        check("lit_rx_data_81", 32'(rx_data), 32'h81);
        check("lit_rx_count_2", 32'(rx_total - base_rx), 32'd2);

        // Address mismatch: target stays silent.
        oe_seen = 1'b0;
        pl_data = '{8'h55, 8'h00, 8'h00, 8'h00};
        xfer(7'h51, 1'b0, 1);
        finish_xfer();
        check("lit_mismatch_no_oe", 32'(oe_seen), 32'd0);

        // Read 0x5A, 0xC3; master NACKs the second byte.
        base_txr = txr_total;
        rd_log.delete();
        pl_data = '{8'h5A, 8'hC3, 8'h00, 8'h00}; pl_valid = 4'b0011;
        xfer(7'h50, 1'b1, 2);
        finish_xfer();
        check("lit_rd_5a", 32'(rd_log[0]), 32'h5A);
        check("lit_rd_c3", 32'(rd_log[1]), 32'hC3);
        check("lit_txr_count_2", 32'(txr_total - base_txr), 32'd2);

        // rx_full before the second data byte.
        base_ovf = ovf_total;
        base_rx  = rx_total;
        pl_data = '{8'h11, 8'h22, 8'h00, 8'h00}; pl_full = 4'b0010;
        xfer(7'h50, 1'b0, 2);
        finish_xfer();
        check("lit_ovf_once", 32'(ovf_total - base_ovf), 32'd1);
        check("lit_rx_only_11", 32'(rx_total - base_rx), 32'd1);
        check("lit_rx_data_11", 32'(rx_data), 32'h11);

        // Repeated START: write 0x10, then read one byte with empty TX FIFO.
        base_txr = txr_total;
        rd_log.delete();
        pl_data = '{8'h10, 8'h00, 8'h00, 8'h00}; pl_full = 4'b0000;
        xfer(7'h50, 1'b0, 1);
        check("lit_rw_before_sr", 32'(rw), 32'd0);
        pl_data = '{8'h77, 8'h00, 8'h00, 8'h00}; pl_valid = 4'b0000;
        xfer(7'h50, 1'b1, 1);
        check("lit_rw_after_sr", 32'(rw), 32'd1);
        finish_xfer();
        check("lit_idle_byte", 32'(rd_log[0]), 32'hFF);
        check("lit_rx_data_10", 32'(rx_data), 32'h10);
        check("lit_no_txr", 32'(txr_total - base_txr), 32'd0);

        // Reset while driving the address ACK.
        start_cond();
        send_bits(8'hA0);
        check("lit_ack_driven", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("lit_async_release", 32'(sda_oe), 32'd0);
        repeat (3) @(posedge core_clk);
        #1;
        rst_n = 1'b1;
        m_scl = 1'b1; wq();
        m_sda = 1'b1; wq();
        check("busy_after_reset", 32'(busy), 32'd0);
        pl_data = '{8'hE7, 8'h00, 8'h00, 8'h00}; pl_full = 4'b0000;
        xfer(7'h50, 1'b0, 1);
        finish_xfer();

        // Disabled target ignores the bus.
        enable = 1'b0;
        oe_seen = 1'b0;
        pl_data = '{8'h42, 8'h00, 8'h00, 8'h00};
        xfer(7'h50, 1'b0, 1);
        finish_xfer();
        check("lit_disabled_no_oe", 32'(oe_seen), 32'd0);
        enable = 1'b1;

        // Randomized transfers, sometimes chained with repeated START.
        for (int t = 0; t < 20; t++) begin
            logic [6:0] addr;
            int n;
            addr = ($urandom_range(0, 2) != 0) ? own_address : 7'($urandom);
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) pl_data[i] = 8'($urandom);
            pl_full  = 4'($urandom) & 4'($urandom);
            pl_valid = 4'($urandom);
            xfer(addr, 1'($urandom), n);
            if (t == 19 || $urandom_range(0, 3) != 0) begin
                finish_xfer();
                if ($urandom_range(0, 3) == 0) own_address = 7'($urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
